// File: rtl/riscv_ctrl_pipe.sv
// RV32I main decoder with EX/MEM/WB control pipeline registers, load-use hazard
// bubbling, external stall and flush with a deferred-flush latch.
module riscv_ctrl_pipe #(
  parameter int ALUOP_W    = 3,
  parameter int EN_M_EXT   = 0,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [6:0]            funct7,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic                  ex_branch,
  output logic                  ex_alusrc,
  output logic                  ex_mux_inp,
  output logic [ALUOP_W-1:0]    ex_aluop,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic [1:0]            wb_memtoreg,
  output logic                  wb_reg_write,
  output logic                  illegal_instr,
  output logic                  hazard,
  output logic [CNT_W-1:0]      bubble_cnt
);

  logic               d_branch, d_memread, d_memwrite, d_alusrc, d_reg_write, d_mux_inp;
  logic [1:0]         d_memtoreg;
  logic [ALUOP_W-1:0] d_aluop;
  logic               legal, uses_rs1, uses_rs2;

  logic               ex_memread, ex_memwrite, ex_reg_write;
  logic [1:0]         ex_memtoreg;
  logic [1:0]         mem_memtoreg;
  logic               mem_reg_write;
  logic               flush_pending;

  logic               eff_flush, load_ex, take_illegal, count_bubble;

  always_comb begin
    d_branch    = 1'b0;
    d_memread   = 1'b0;
    d_memwrite  = 1'b0;
    d_alusrc    = 1'b0;
    d_reg_write = 1'b0;
    d_mux_inp   = 1'b0;
    d_memtoreg  = 2'b11;
    d_aluop     = '0;
    legal       = 1'b1;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      7'b0110011: begin
        d_memtoreg = 2'b00; d_reg_write = 1'b1; uses_rs2 = 1'b1;
        if (funct7 == 7'b0000001) begin
          if (EN_M_EXT != 0) d_aluop = ALUOP_W'(3'b111);
          else               legal   = 1'b0;
        end
      end
      7'b0010011: begin
        d_memtoreg = 2'b00; d_alusrc = 1'b1; d_reg_write = 1'b1; d_aluop = ALUOP_W'(3'b001);
      end
      7'b0000011: begin
        d_memtoreg = 2'b01; d_alusrc = 1'b1; d_reg_write = 1'b1; d_aluop = ALUOP_W'(3'b010);
        d_memread  = 1'b1;
      end
      7'b0100011: begin
        d_alusrc = 1'b1; d_aluop = ALUOP_W'(3'b011); d_memwrite = 1'b1; uses_rs2 = 1'b1;
      end
      7'b1100011: begin
        d_memtoreg = 2'b00; d_aluop = ALUOP_W'(3'b100); d_branch = 1'b1; uses_rs2 = 1'b1;
      end
      7'b1101111: begin
        d_memtoreg = 2'b10; d_alusrc = 1'b1; d_reg_write = 1'b1; d_aluop = ALUOP_W'(3'b101);
        uses_rs1   = 1'b0;
      end
      7'b1100111: begin
        d_memtoreg = 2'b10; d_alusrc = 1'b1; d_reg_write = 1'b1; d_aluop = ALUOP_W'(3'b001);
        d_mux_inp  = 1'b1;
      end
      7'b0110111: begin
        d_memtoreg = 2'b10; d_alusrc = 1'b1; d_reg_write = 1'b1; d_aluop = ALUOP_W'(3'b110);
        uses_rs1   = 1'b0;
      end
      7'b0010111: begin
        d_memtoreg = 2'b10; d_alusrc = 1'b1; d_reg_write = 1'b1;
        uses_rs1   = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  assign hazard = in_valid & ex_valid & ex_memread & (ex_rd != '0) &
                  ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));
  assign in_ready     = !stall & !hazard;
  assign eff_flush    = flush | flush_pending;
  assign load_ex      = !eff_flush & !hazard & in_valid & legal;
  assign take_illegal = !eff_flush & !hazard & in_valid & !legal;
  assign count_bubble = !eff_flush & hazard & (bubble_cnt != '1);

  // Every stage that is not valid carries bubble controls, so the outputs need no gating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_branch     <= 1'b0;
      ex_memread    <= 1'b0;
      ex_memwrite   <= 1'b0;
      ex_alusrc     <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mux_inp    <= 1'b0;
      ex_memtoreg   <= 2'b11;
      ex_aluop      <= '0;
      ex_rd         <= '0;
      mem_valid     <= 1'b0;
      mem_memread   <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_memtoreg  <= 2'b11;
      mem_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_memtoreg   <= 2'b11;
      wb_reg_write  <= 1'b0;
      illegal_instr <= 1'b0;
      bubble_cnt    <= '0;
      flush_pending <= 1'b0;
    end else if (stall) begin
      illegal_instr <= 1'b0;
      if (flush) flush_pending <= 1'b1;
    end else begin
      mem_valid     <= ex_valid;
      mem_memread   <= ex_memread;
      mem_memwrite  <= ex_memwrite;
      mem_memtoreg  <= ex_memtoreg;
      mem_reg_write <= ex_reg_write;
      wb_valid      <= mem_valid;
      wb_memtoreg   <= mem_memtoreg;
      wb_reg_write  <= mem_reg_write;
      flush_pending <= 1'b0;
      illegal_instr <= take_illegal;
      if (count_bubble) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (load_ex) begin
        ex_valid     <= 1'b1;
        ex_branch    <= d_branch;
        ex_memread   <= d_memread;
        ex_memwrite  <= d_memwrite;
        ex_alusrc    <= d_alusrc;
        ex_reg_write <= d_reg_write;
        ex_mux_inp   <= d_mux_inp;
        ex_memtoreg  <= d_memtoreg;
        ex_aluop     <= d_aluop;
        ex_rd        <= rd;
      end else begin
        ex_valid     <= 1'b0;
        ex_branch    <= 1'b0;
        ex_memread   <= 1'b0;
        ex_memwrite  <= 1'b0;
        ex_alusrc    <= 1'b0;
        ex_reg_write <= 1'b0;
        ex_mux_inp   <= 1'b0;
        ex_memtoreg  <= 2'b11;
        ex_aluop     <= '0;
        ex_rd        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Bench for riscv_ctrl_pipe: a base instance and an M-extension instance with a
// narrow bubble counter, both checked against a stage-list reference model.
module tb_riscv_ctrl_pipe;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
                         OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [6:0] opcode = 7'd0, funct7 = 7'd0;
  logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;

  logic in_ready, ex_valid, mem_valid, wb_valid, ex_branch, ex_alusrc, ex_mux_inp;
  logic [2:0] ex_aluop;
  logic [4:0] ex_rd;
  logic mem_memread, mem_memwrite, wb_reg_write, illegal_instr, hazard;
  logic [1:0] wb_memtoreg;
  logic [15:0] bubble_cnt;

  logic in_ready_m, ex_valid_m, mem_valid_m, wb_valid_m, ex_branch_m, ex_alusrc_m, ex_mux_inp_m;
  logic [3:0] ex_aluop_m;
  logic [4:0] ex_rd_m;
  logic mem_memread_m, mem_memwrite_m, wb_reg_write_m, illegal_instr_m, hazard_m;
  logic [1:0] wb_memtoreg_m;
  logic [1:0] bubble_cnt_m;

  always #5 clk = ~clk;

  riscv_ctrl_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .ex_branch(ex_branch), .ex_alusrc(ex_alusrc),
    .ex_mux_inp(ex_mux_inp), .ex_aluop(ex_aluop), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .wb_memtoreg(wb_memtoreg),
    .wb_reg_write(wb_reg_write), .illegal_instr(illegal_instr), .hazard(hazard),
    .bubble_cnt(bubble_cnt)
  );

  riscv_ctrl_pipe #(.ALUOP_W(4), .EN_M_EXT(1), .REG_ADDR_W(5), .CNT_W(2)) dut_m (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
    .opcode(opcode), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .flush(flush), .ex_valid(ex_valid_m), .mem_valid(mem_valid_m),
    .wb_valid(wb_valid_m), .ex_branch(ex_branch_m), .ex_alusrc(ex_alusrc_m),
    .ex_mux_inp(ex_mux_inp_m), .ex_aluop(ex_aluop_m), .ex_rd(ex_rd_m),
    .mem_memread(mem_memread_m), .mem_memwrite(mem_memwrite_m), .wb_memtoreg(wb_memtoreg_m),
    .wb_reg_write(wb_reg_write_m), .illegal_instr(illegal_instr_m), .hazard(hazard_m),
    .bubble_cnt(bubble_cnt_m)
  );

  typedef struct packed {
    logic valid, branch, memread;
    logic [1:0] memtoreg;
    logic memwrite, alusrc, reg_write;
    logic [3:0] aluop;
    logic mux_inp;
    logic [4:0] rd;
  } stg_t;

  localparam stg_t BUB = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 5'd0};

  // Index 0 models dut, index 1 models dut_m.
  stg_t mex[2], mmem[2], mwb[2];
  bit   mpend[2], mill[2];
  int   mcnt[2];
  int   cmax[2] = '{65535, 3};
  bit   mext[2] = '{1'b0, 1'b1};
  bit   hz_exp[2];
  logic hz_obs[2], rdy_obs[2];

  int n_cmp = 0, n_fail = 0;

  function automatic void decode(input logic [6:0] opc, input logic [6:0] f7, input bit m_en,
                                 input logic [4:0] d, output stg_t s, output bit ok);
    s = BUB; ok = 1'b1;
    s.valid = 1'b1; s.rd = d;
    case (opc)
      OP_R:    begin s.memtoreg = 2'b00; s.reg_write = 1;
                     if (f7 == 7'b0000001) begin if (m_en) s.aluop = 4'd7; else ok = 0; end end
      OP_I:    begin s.memtoreg = 2'b00; s.alusrc = 1; s.reg_write = 1; s.aluop = 4'd1; end
      OP_LD:   begin s.memtoreg = 2'b01; s.alusrc = 1; s.reg_write = 1; s.aluop = 4'd2; s.memread = 1; end
      OP_ST:   begin s.alusrc = 1; s.aluop = 4'd3; s.memwrite = 1; end
      OP_BR:   begin s.memtoreg = 2'b00; s.aluop = 4'd4; s.branch = 1; end
      OP_JAL:  begin s.memtoreg = 2'b10; s.alusrc = 1; s.reg_write = 1; s.aluop = 4'd5; end
      OP_JALR: begin s.memtoreg = 2'b10; s.alusrc = 1; s.reg_write = 1; s.aluop = 4'd1; s.mux_inp = 1; end
      OP_LUI:  begin s.memtoreg = 2'b10; s.alusrc = 1; s.reg_write = 1; s.aluop = 4'd6; end
      OP_AUI:  begin s.memtoreg = 2'b10; s.alusrc = 1; s.reg_write = 1; end
      default: ok = 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mex[k] = BUB; mmem[k] = BUB; mwb[k] = BUB;
      mpend[k] = 0; mill[k] = 0; mcnt[k] = 0;
    end
  endtask

  // Drives one decode-slot cycle, captures the combinational outputs before the edge,
  // then advances the reference model across the edge.
  task automatic tick(input bit iv, input logic [6:0] opc, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input bit st, input bit fl);
    stg_t dec;
    bit ok, u1, u2;
    in_valid = iv; opcode = opc; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
    stall = st; flush = fl;
    #1;
    hz_obs[0] = hazard;   rdy_obs[0] = in_ready;
    hz_obs[1] = hazard_m; rdy_obs[1] = in_ready_m;
    u1 = !(opc == OP_LUI || opc == OP_AUI || opc == OP_JAL);
    u2 = (opc == OP_R || opc == OP_ST || opc == OP_BR);
    for (int k = 0; k < 2; k++)
      hz_exp[k] = iv && mex[k].valid && mex[k].memread && mex[k].rd != 0 &&
                  ((u1 && mex[k].rd == s1) || (u2 && mex[k].rd == s2));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (st) begin
        if (fl) mpend[k] = 1;
        mill[k] = 0;
      end else begin
        mwb[k] = mmem[k]; mmem[k] = mex[k];
        if (fl || mpend[k]) begin
          mex[k] = BUB; mill[k] = 0;
        end else if (hz_exp[k]) begin
          mex[k] = BUB; mill[k] = 0;
          if (mcnt[k] < cmax[k]) mcnt[k]++;
        end else begin
          decode(opc, f7, mext[k], d, dec, ok);
          mex[k] = (iv && ok) ? dec : BUB;
          mill[k] = iv && !ok;
        end
        mpend[k] = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({ex_valid, mem_valid, wb_valid, wb_memtoreg, wb_reg_write, illegal_instr, ex_rd, ex_aluop} !==
        {3'b000, 2'b11, 1'b0, 1'b0, 5'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b%b%b mtr=%b rw=%b ill=%b rd=%0d op=%0d, want 000 11 0 0 0 0",
               ex_valid, mem_valid, wb_valid, wb_memtoreg, wb_reg_write, illegal_instr, ex_rd, ex_aluop);
    end
    n_cmp++;
    if (bubble_cnt !== 16'd0 || ex_memtoreg_chk() !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_cnt: got cnt=%0d mem_rd=%b mem_wr=%b, want 0 0 0", bubble_cnt, mem_memread, mem_memwrite);
    end
  endtask

  function automatic logic ex_memtoreg_chk();
    return (mem_memread === 1'b0) && (mem_memwrite === 1'b0) && (ex_branch === 1'b0);
  endfunction

  task automatic test_hazard();
    tick(1, OP_LD, 7'd0, 5'd3, 5'd1, 5'd0, 0, 0);
    tick(1, OP_R, 7'd0, 5'd4, 5'd1, 5'd3, 0, 0);
    n_cmp++;
    if (hz_obs[0] !== 1'b1 || rdy_obs[0] !== 1'b0) begin
      n_fail++; $display("FAIL hazard_detect: got hazard=%b in_ready=%b, want 1 0", hz_obs[0], rdy_obs[0]);
    end
    n_cmp++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 16'd1 || mem_memread !== 1'b1) begin
      n_fail++; $display("FAIL hazard_bubble: got ex_valid=%b cnt=%0d mem_memread=%b, want 0 1 1",
                         ex_valid, bubble_cnt, mem_memread);
    end
    tick(1, OP_R, 7'd0, 5'd4, 5'd1, 5'd3, 0, 0);
    n_cmp++;
    if (hz_obs[0] !== 1'b0 || ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_aluop !== 3'd0) begin
      n_fail++; $display("FAIL hazard_replay: got hazard=%b ex_valid=%b rd=%0d op=%0d, want 0 1 4 0",
                         hz_obs[0], ex_valid, ex_rd, ex_aluop);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, OP_R, 7'd0, 5'd1, 5'd2, 5'd6, 0, 0);
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_aluop !== 3'b000) begin
      n_fail++; $display("FAIL b2b_c1: got ex_valid=%b ex_aluop=%b, want 1 000", ex_valid, ex_aluop);
    end
    tick(1, OP_LD, 7'd0, 5'd5, 5'd2, 5'd0, 0, 0);
    tick(0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    n_cmp++;
    if (mem_memread !== 1'b1 || mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_c3: got mem_memread=%b mem_valid=%b, want 1 1", mem_memread, mem_valid);
    end
    tick(0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    n_cmp++;
    if (wb_memtoreg !== 2'b01 || wb_reg_write !== 1'b1 || wb_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_c4: got wb_memtoreg=%b wb_reg_write=%b wb_valid=%b, want 01 1 1",
                         wb_memtoreg, wb_reg_write, wb_valid);
    end
  endtask

  task automatic test_rd_zero();
    tick(1, OP_LD, 7'd0, 5'd0, 5'd1, 5'd0, 0, 0);
    tick(1, OP_R, 7'd0, 5'd2, 5'd0, 5'd0, 0, 0);
    n_cmp++;
    if (hz_obs[0] !== 1'b0 || rdy_obs[0] !== 1'b1 || ex_valid !== 1'b1 || bubble_cnt !== 16'(mcnt[0])) begin
      n_fail++; $display("FAIL rd_zero: got hazard=%b in_ready=%b ex_valid=%b cnt=%0d, want 0 1 1 %0d",
                         hz_obs[0], rdy_obs[0], ex_valid, bubble_cnt, mcnt[0]);
    end
  endtask

  task automatic test_flush_stall();
    tick(1, OP_I, 7'd0, 5'd4, 5'd1, 5'd0, 0, 0);
    tick(1, OP_R, 7'd0, 5'd7, 5'd1, 5'd2, 1, 1);
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_aluop !== 3'b001 || ex_rd !== 5'd4 || illegal_instr !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold: got ex_valid=%b op=%b rd=%0d ill=%b, want 1 001 4 0",
                         ex_valid, ex_aluop, ex_rd, illegal_instr);
    end
    tick(1, OP_R, 7'd0, 5'd7, 5'd1, 5'd2, 0, 0);
    n_cmp++;
    if (ex_valid !== 1'b0 || mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL deferred_flush: got ex_valid=%b mem_valid=%b, want 0 1", ex_valid, mem_valid);
    end
    tick(1, OP_R, 7'd0, 5'd7, 5'd1, 5'd2, 0, 0);
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
      n_fail++; $display("FAIL flush_resume: got ex_valid=%b ex_rd=%0d, want 1 7", ex_valid, ex_rd);
    end
  endtask

  task automatic test_illegal();
    tick(1, OP_BAD, 7'd0, 5'd3, 5'd1, 5'd2, 0, 0);
    n_cmp++;
    if (illegal_instr !== 1'b1 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_pulse: got ill=%b ex_valid=%b, want 1 0", illegal_instr, ex_valid);
    end
    tick(0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0, 0);
    n_cmp++;
    if (illegal_instr !== 1'b0) begin
      n_fail++; $display("FAIL illegal_one_cycle: got ill=%b, want 0", illegal_instr);
    end
    tick(1, OP_R, 7'b0000001, 5'd6, 5'd1, 5'd2, 0, 0);
    n_cmp++;
    if (illegal_instr !== 1'b1 || ex_valid !== 1'b0) begin
      n_fail++; $display("FAIL mext_off: got ill=%b ex_valid=%b, want 1 0", illegal_instr, ex_valid);
    end
    n_cmp++;
    if (ex_aluop_m !== 4'b0111 || ex_valid_m !== 1'b1 || illegal_instr_m !== 1'b0) begin
      n_fail++; $display("FAIL mext_on: got op=%b ex_valid=%b ill=%b, want 0111 1 0",
                         ex_aluop_m, ex_valid_m, illegal_instr_m);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[10];
    logic [20:0] obs, exp;
    logic [6:0] opc, f7;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI, OP_BAD};
    for (int c = 0; c < 1500; c++) begin
      opc = ops[$urandom_range(0, 9)];
      f7 = ($urandom_range(0, 3) == 0) ? 7'b0000001 : 7'b0000000;
      tick($urandom_range(0, 4) != 0, opc, f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 6) == 0, $urandom_range(0, 8) == 0);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (hz_obs[k] !== hz_exp[k] || rdy_obs[k] !== (!stall && !hz_exp[k])) begin
          n_fail++; $display("FAIL rand_comb[%0d] cyc %0d: got hazard=%b in_ready=%b, want %b %b",
                             k, c, hz_obs[k], rdy_obs[k], hz_exp[k], !stall && !hz_exp[k]);
        end
        exp = {mex[k].valid, mex[k].branch, mex[k].alusrc, mex[k].mux_inp, mex[k].aluop, mex[k].rd,
               mmem[k].valid, mmem[k].memread, mmem[k].memwrite,
               mwb[k].valid, mwb[k].memtoreg, mwb[k].reg_write, mill[k]};
        if (k == 0)
          obs = {ex_valid, ex_branch, ex_alusrc, ex_mux_inp, 1'b0, ex_aluop, ex_rd,
                 mem_valid, mem_memread, mem_memwrite, wb_valid, wb_memtoreg, wb_reg_write, illegal_instr};
        else
          obs = {ex_valid_m, ex_branch_m, ex_alusrc_m, ex_mux_inp_m, ex_aluop_m, ex_rd_m,
                 mem_valid_m, mem_memread_m, mem_memwrite_m, wb_valid_m, wb_memtoreg_m, wb_reg_write_m,
                 illegal_instr_m};
        n_cmp++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL rand_stages[%0d] cyc %0d: got %h, want %h", k, c, obs, exp);
        end
      end
      n_cmp++;
      if (bubble_cnt !== 16'(mcnt[0]) || bubble_cnt_m !== 2'(mcnt[1])) begin
        n_fail++; $display("FAIL rand_bubble_cnt cyc %0d: got %0d/%0d, want %0d/%0d",
                           c, bubble_cnt, bubble_cnt_m, mcnt[0], mcnt[1]);
      end
    end
    n_cmp++;
    if (mcnt[1] == 3 && bubble_cnt_m !== 2'b11) begin
      n_fail++; $display("FAIL saturate: got %0d, want 3", bubble_cnt_m);
    end
  endtask

  task automatic test_async_reset();
    tick(1, OP_LD, 7'd0, 5'd1, 5'd2, 5'd0, 0, 0);
    tick(1, OP_R, 7'd0, 5'd2, 5'd3, 5'd3, 0, 0);
    tick(1, OP_I, 7'd0, 5'd3, 5'd3, 5'd0, 0, 0);
    reset = 1'b1;
    #2;
    n_cmp++;
    if ({ex_valid, mem_valid, wb_valid, wb_memtoreg, wb_reg_write, bubble_cnt} !== {3'b000, 2'b11, 1'b0, 16'd0} ||
        {ex_valid_m, mem_valid_m, wb_valid_m, wb_memtoreg_m} !== {3'b000, 2'b11}) begin
      n_fail++; $display("FAIL async_reset: got v=%b%b%b mtr=%b rw=%b cnt=%0d, want 000 11 0 0",
                         ex_valid, mem_valid, wb_valid, wb_memtoreg, wb_reg_write, bubble_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    test_reset();
    reset = 1'b0;
    test_hazard();
    test_back_to_back();
    test_rd_zero();
    test_flush_stall();
    test_illegal();
    test_random();
    test_async_reset();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
